photo_sensor_conditioner: RTL

//  Front end for the bank queue manager: conditions the raw back (entry) and front (exit) photocell lines.
//  Per channel: synchronises, debounces, and emits one clean single-cycle pulse per person that fully passes.

---
 rtl/queue_pkg.sv | 15 +
 rtl/sensor_channel.sv | 103 ++++++++++
 rtl/photo_sensor_conditioner.sv | 39 +++
 3 files changed

// File: rtl/queue_pkg.sv
// Shared definitions for the bank-queue front end: photocell channel state
// encoding and the sensor polarity.
package queue_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BLK_PEND = 3'd1,
        BLOCKED  = 3'd2,
        CLR_PEND = 3'd3,
        FAULT    = 3'd4
    } chan_state_t;

    localparam logic BEAM_CLEAR = 1'b1;

endpackage

// File: rtl/sensor_channel.sv
// One photocell channel. It synchronises and debounces the raw line, then
// emits a single-cycle pulse per person and flags a beam that stays blocked.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | beam accepted as clear, waiting for a break
//   BLK_PEND | beam broken, debouncing the break
//   BLOCKED  | break accepted (person in beam); counting towards stuck fault
//   CLR_PEND | beam clear again, debouncing; completion emits the pulse
//   FAULT    | beam blocked too long; waits for a debounced clear, no pulse
module sensor_channel
    import queue_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic fault
);

    localparam int CW = $clog2(STUCK_CYCLES);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_FULL   = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    logic          sync_meta;
    logic          sync_out;
    chan_state_t   state;
    chan_state_t   state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          clear;
    logic          pulse_nxt;
    logic          fault_nxt;

    assign clear   = (sync_out == BEAM_CLEAR);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= BEAM_CLEAR;
            sync_out  <= BEAM_CLEAR;
            state     <= IDLE;
            cnt       <= '0;
            pulse     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pulse     <= pulse_nxt;
            fault     <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        pulse_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (!clear) state_nxt = BLK_PEND;
            end
            BLK_PEND: begin
                if (clear)                 state_nxt = IDLE;
                else if (cnt == DEB_LAST)  state_nxt = BLOCKED;
                else                       cnt_nxt   = cnt_inc;
            end
            BLOCKED: begin
                if (clear)                  state_nxt = CLR_PEND;
                else if (cnt == STUCK_LAST) state_nxt = FAULT;
                else                        cnt_nxt   = cnt_inc;
            end
            CLR_PEND: begin
                if (!clear) begin
                    state_nxt = BLOCKED;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            FAULT: begin
                // The first clear cycle only arms the count, so leaving FAULT
                // takes as long after the release as a normal pulse does.
                if (clear) begin
                    if (cnt == DEB_FULL) state_nxt = IDLE;
                    else                 cnt_nxt   = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
        fault_nxt = (state_nxt == FAULT);
    end

endmodule

// File: rtl/photo_sensor_conditioner.sv
// Entry/exit photocell conditioner feeding the queue manager's a/b inputs;
// two independent sensor channels and nothing else.
module photo_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic back_raw,
    input  logic front_raw,
    output logic back_pulse,
    output logic front_pulse,
    output logic back_fault,
    output logic front_fault
);

    sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_back (
        .clk  (clk),
        .reset(reset),
        .raw  (back_raw),
        .pulse(back_pulse),
        .fault(back_fault)
    );

    sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_front (
        .clk  (clk),
        .reset(reset),
        .raw  (front_raw),
        .pulse(front_pulse),
        .fault(front_fault)
    );

endmodule
